// File: rtl/fp32_mul_core_if.sv
// Handshake and operand/result bundle between the FP32 unpack stage, the
// multiplier core and the result consumer.
interface fp32_mul_core_if;
    logic        in_valid;
    logic        in_ready;
    logic        sign_a;
    logic [7:0]  exponent_a;
    logic [22:0] fraction_a;
    logic        sign_b;
    logic [7:0]  exponent_b;
    logic [22:0] fraction_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] output_z;

    modport master (
        output in_valid, sign_a, exponent_a, fraction_a,
        output sign_b, exponent_b, fraction_b, out_ready,
        input  in_ready, out_valid, output_z
    );

    modport slave (
        input  in_valid, sign_a, exponent_a, fraction_a,
        input  sign_b, exponent_b, fraction_b, out_ready,
        output in_ready, out_valid, output_z
    );
endinterface

// File: rtl/fp32_mul_core.sv
// Iterative FP32 multiplier: 24-cycle shift-add mantissa product, normalize,
// round-to-nearest-even and pack. One operation in flight, DAZ/FTZ.
module fp32_mul_core (
    input  logic             clk,
    input  logic             rst,
    fp32_mul_core_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MULT  = 3'd1,
        NORM  = 3'd2,
        ROUND = 3'd3,
        DONE  = 3'd4
    } state_t;

    function automatic logic is_nan(input logic [7:0] e, input logic [22:0] f);
        return (e == 8'hFF) && (f != 23'd0);
    endfunction

    function automatic logic is_inf(input logic [7:0] e, input logic [22:0] f);
        return (e == 8'hFF) && (f == 23'd0);
    endfunction

    function automatic logic is_zero(input logic [7:0] e);
        return (e == 8'h00);
    endfunction

    state_t             state_r, next_state_s;
    logic               sign_r;
    logic signed [9:0]  exp_r;
    logic        [47:0] mcand_r;
    logic        [23:0] mplier_r;
    logic        [47:0] acc_r;
    logic        [4:0]  cnt_r;
    logic        [22:0] mant_r;
    logic               guard_r, sticky_r;
    logic        [31:0] z_r;
    logic               in_ready_r, out_valid_r;
    logic               in_ready_s, out_valid_s;

    logic               accept_s, special_s, sign_s;
    logic               nan_a_s, inf_a_s, zero_a_s, nan_b_s, inf_b_s, zero_b_s;
    logic        [31:0] special_z_s;
    logic               round_up_s;
    logic        [23:0] mant_sum_s;
    logic signed [9:0]  exp_rnd_s;
    logic        [31:0] pack_z_s;

    assign accept_s = bus.in_valid && (state_r == IDLE);
    assign sign_s   = bus.sign_a ^ bus.sign_b;
    assign nan_a_s  = is_nan(bus.exponent_a, bus.fraction_a);
    assign inf_a_s  = is_inf(bus.exponent_a, bus.fraction_a);
    assign zero_a_s = is_zero(bus.exponent_a);
    assign nan_b_s  = is_nan(bus.exponent_b, bus.fraction_b);
    assign inf_b_s  = is_inf(bus.exponent_b, bus.fraction_b);
    assign zero_b_s = is_zero(bus.exponent_b);
    assign special_s = nan_a_s | inf_a_s | zero_a_s | nan_b_s | inf_b_s | zero_b_s;

    // Special-operand result, priority NaN/invalid > Inf > zero
    always_comb begin
        if (nan_a_s || nan_b_s || (inf_a_s && zero_b_s) || (inf_b_s && zero_a_s)) begin
            special_z_s = 32'h7FC0_0000;
        end else if (inf_a_s || inf_b_s) begin
            special_z_s = {sign_s, 8'hFF, 23'd0};
        end else begin
            special_z_s = {sign_s, 31'd0};
        end
    end

    // Round-to-nearest-even and pack with overflow to Inf / flush to zero
    always_comb begin
        round_up_s = guard_r && (sticky_r || mant_r[0]);
        mant_sum_s = {1'b0, mant_r} + {23'd0, round_up_s};
        exp_rnd_s  = exp_r + $signed({9'd0, mant_sum_s[23]});
        if (exp_rnd_s >= 10'sd255) begin
            pack_z_s = {sign_r, 8'hFF, 23'd0};
        end else if (exp_rnd_s <= 10'sd0) begin
            pack_z_s = {sign_r, 31'd0};
        end else begin
            pack_z_s = {sign_r, exp_rnd_s[7:0], mant_sum_s[22:0]};
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_state_s = special_s ? DONE : MULT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            MULT: begin
                if (cnt_r == 5'd23) begin
                    next_state_s = NORM;
                end else begin
                    next_state_s = MULT;
                end
            end
            NORM:  next_state_s = ROUND;
            ROUND: next_state_s = DONE;
            DONE: begin
                if (out_valid_r && bus.out_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DONE;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Handshake outputs; out_valid follows DONE by one cycle and drops on handshake
    always_comb begin
        in_ready_s  = (next_state_s == IDLE);
        out_valid_s = (state_r == DONE) && !(out_valid_r && bus.out_ready);
    end

    // Registered handshake outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
        end
    end

    // Datapath: operand latch, shift-add multiply, normalize, round/pack
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sign_r   <= 1'b0;
            exp_r    <= 10'sd0;
            mcand_r  <= 48'd0;
            mplier_r <= 24'd0;
            acc_r    <= 48'd0;
            cnt_r    <= 5'd0;
            mant_r   <= 23'd0;
            guard_r  <= 1'b0;
            sticky_r <= 1'b0;
            z_r      <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        sign_r <= sign_s;
                        if (special_s) begin
                            z_r <= special_z_s;
                        end else begin
                            exp_r    <= $signed({2'b00, bus.exponent_a} + {2'b00, bus.exponent_b} - 10'd127);
                            mcand_r  <= {24'd0, 1'b1, bus.fraction_a};
                            mplier_r <= {1'b1, bus.fraction_b};
                            acc_r    <= 48'd0;
                            cnt_r    <= 5'd0;
                        end
                    end
                end
                MULT: begin
                    if (mplier_r[0]) begin
                        acc_r <= acc_r + mcand_r;
                    end
                    mcand_r  <= {mcand_r[46:0], 1'b0};
                    mplier_r <= {1'b0, mplier_r[23:1]};
                    cnt_r    <= (cnt_r == 5'd23) ? 5'd0 : cnt_r + 5'd1;
                end
                NORM: begin
                    if (acc_r[47]) begin
                        mant_r   <= acc_r[46:24];
                        guard_r  <= acc_r[23];
                        sticky_r <= |acc_r[22:0];
                        exp_r    <= exp_r + 10'sd1;
                    end else begin
                        mant_r   <= acc_r[45:23];
                        guard_r  <= acc_r[22];
                        sticky_r <= |acc_r[21:0];
                    end
                end
                ROUND: begin
                    z_r <= pack_z_s;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.output_z  = z_r;
endmodule

// File: tb/tb_fp32_mul_core.sv
// Self-checking bench for fp32_mul_core: directed test-plan vectors plus
// randomized operands against an integer-arithmetic FP32 multiply model.
module tb_fp32_mul_core;
    logic clk = 1'b0;
    logic rst = 1'b0;
    fp32_mul_core_if bus();

    fp32_mul_core dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int tests = 0;
    int failures = 0;
    logic [31:0] q[$];
    bit rand_bp = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: exact integer product, then round-to-nearest-even by remainder
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
        logic s;
        int ea, eb, e, sh;
        longint unsigned ma, mb, p, mant, rem, half;
        bit nan_a, inf_a, zero_a, nan_b, inf_b, zero_b;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        nan_a = (ea == 255) && (a[22:0] != 23'd0);
        inf_a = (ea == 255) && (a[22:0] == 23'd0);
        zero_a = (ea == 0);
        nan_b = (eb == 255) && (b[22:0] != 23'd0);
        inf_b = (eb == 255) && (b[22:0] == 23'd0);
        zero_b = (eb == 0);
        if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) return 32'h7FC0_0000;
        if (inf_a || inf_b) return {s, 8'hFF, 23'd0};
        if (zero_a || zero_b) return {s, 31'd0};
        ma = 64'h80_0000 + 64'(a[22:0]);
        mb = 64'h80_0000 + 64'(b[22:0]);
        p  = ma * mb;
        e  = ea + eb - 127;
        sh = (p >= (64'd1 << 47)) ? 24 : 23;
        if (sh == 24) e++;
        mant = p >> sh;
        rem  = p - (mant << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && mant[0])) mant++;
        if (mant >= (64'd1 << 24)) begin
            mant = mant >> 1;
            e++;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, 8'(e), mant[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [7:0]  e;
        logic [22:0] f;
        case ($urandom_range(0, 15))
            0:       e = 8'h00;
            1:       e = 8'hFF;
            2, 3:    e = 8'($urandom_range(200, 254));
            4, 5:    e = 8'($urandom_range(1, 10));
            default: e = 8'($urandom_range(100, 154));
        endcase
        f = 23'($urandom);
        if ($urandom_range(0, 7) == 0) f = 23'd0;
        return {1'($urandom_range(0, 1)), e, f};
    endfunction

    // Compare process: every cycle a result is presented it must match the oldest expectation
    always @(negedge clk) begin
        if (!rst) begin
            q.delete();
        end else if (bus.out_valid) begin
            if (q.size() == 0) begin
                check("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                check("output_z", bus.output_z, q[0]);
                check("in_ready_while_valid", {31'd0, bus.in_ready}, 32'd0);
                if (bus.out_ready) void'(q.pop_front());
            end
        end
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] b);
        {bus.sign_a, bus.exponent_a, bus.fraction_a} = a;
        {bus.sign_b, bus.exponent_b, bus.fraction_b} = b;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input int exp_lat);
        int n;
        logic acc;
        logic busy_ok;
        drive(a, b);
        bus.in_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b0;
        if (!acc) begin
            check("issue_timeout", 32'd1, 32'd0);
        end else begin
            q.push_back(model(a, b));
            if (exp_lat > 0) begin
                n = 0;
                busy_ok = 1'b1;
                while (!bus.out_valid && n < 60) begin
                    if (bus.in_ready) busy_ok = 1'b0;
                    @(posedge clk);
                    #1;
                    n++;
                end
                check("latency", 32'(n), 32'(exp_lat));
                check("busy_in_ready_low", {31'd0, busy_ok}, 32'd1);
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 400) begin
            @(posedge clk);
            #1;
            if (rand_bp) bus.out_ready = 1'($urandom_range(0, 1));
            n++;
        end
        check("drain_timeout", 32'(q.size()), 32'd0);
        bus.out_ready = 1'b1;
    endtask

    logic [31:0] va [10] = '{32'h3FC00000, 32'h3F800001, 32'h3F800001, 32'h7F800000, 32'hFF800000,
                             32'h80000000, 32'h00000001, 32'h7F000000, 32'h00800000, 32'h7F800001};
    logic [31:0] vb [10] = '{32'h40000000, 32'h3F800001, 32'h3FC00000, 32'h00000000, 32'h40000000,
                             32'h3F800000, 32'h3F800000, 32'h40000000, 32'h3F000000, 32'h3F800000};
    logic [31:0] vz [10] = '{32'h40400000, 32'h3F800002, 32'h3FC00002, 32'h7FC00000, 32'hFF800000,
                             32'h80000000, 32'h00000000, 32'h7F800000, 32'h00000000, 32'h7FC00000};
    int          vl [10] = '{27, 27, 27, 1, 1, 1, 1, 27, 27, 1};

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive(32'd0, 32'd0);
        #12;
        check("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("reset_output_z", bus.output_z, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            check("model_pin", model(va[i], vb[i]), vz[i]);
            issue(va[i], vb[i], vl[i]);
            drain();
        end

        // Backpressure with a pending input that must be ignored
        bus.out_ready = 1'b0;
        issue(32'h3FC00000, 32'h40000000, 27);
        drive(32'h3F800000, 32'h3F800000);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
            check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
            check("bp_output_z", bus.output_z, 32'h40400000);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("release_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("release_in_ready", {31'd0, bus.in_ready}, 32'd1);
        repeat (30) @(posedge clk);
        #1;
        check("pending_not_accepted", {31'd0, bus.out_valid}, 32'd0);
        check("retain_output_z", bus.output_z, 32'h40400000);

        // Reset during MULT
        issue(32'h3F800001, 32'h3FC00000, 0);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("midrst_output_z", bus.output_z, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        check("midrst_flushed", 32'(q.size()), 32'd0);
        issue(32'h3FC00000, 32'h40000000, 27);
        drain();
        check("after_rst_output_z", bus.output_z, 32'h40400000);

        // Randomized operands with random backpressure
        rand_bp = 1'b1;
        for (int i = 0; i < 200; i++) begin
            issue(rand_op(), rand_op(), 0);
            drain();
        end
        rand_bp = 1'b0;

        repeat (5) @(posedge clk);
        #1;
        check("final_queue_empty", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
